// File: rtl/eco32_core_ifu_icu_pt_ctrl_pkg.sv
// Shared types and constants for the ICU page-table write sequencer.
package eco32_core_ifu_icu_pt_ctrl_pkg;

  localparam int DESC_W = 36;
  localparam int TID_W  = 1;
  localparam int NTID   = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFILL,
    ST_FLUSH,
    ST_HOLD
  } pt_state_e;

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/eco32_core_ifu_icu_pt_ctrl_if.sv
// Request/ack handshakes from the ICU and the shared write bus to the way tables.
interface eco32_core_ifu_icu_pt_ctrl_if
  import eco32_core_ifu_icu_pt_ctrl_pkg::*;
#(
  parameter int PAW  = 5,
  parameter int WAYS = 2
);
  localparam int WB = way_bits(WAYS);

  logic [NTID-1:0]        rf_req;
  logic [NTID*PAW-1:0]    rf_page;
  logic [NTID*DESC_W-1:0] rf_desc;
  logic [NTID-1:0]        rf_ack;
  logic [WB-1:0]          rf_way;
  logic [NTID-1:0]        fl_req;
  logic [NTID-1:0]        fl_ack;
  logic                   o_busy;
  logic [WAYS-1:0]        wr_ena;
  logic [TID_W-1:0]       wr_tid;
  logic [PAW-1:0]         wr_page;
  logic [DESC_W-1:0]      wr_descriptor;

  modport master (
    output rf_req, rf_page, rf_desc, fl_req,
    input  rf_ack, rf_way, fl_ack, o_busy, wr_ena, wr_tid, wr_page, wr_descriptor
  );

  modport slave (
    input  rf_req, rf_page, rf_desc, fl_req,
    output rf_ack, rf_way, fl_ack, o_busy, wr_ena, wr_tid, wr_page, wr_descriptor
  );

endinterface

// File: rtl/eco32_core_ifu_icu_pt_arb.sv
// Two-requester round-robin arbiter; a tie goes to the thread not granted last.
module eco32_core_ifu_icu_pt_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    last_d = upd ? gnt[1] : last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/eco32_core_ifu_icu_pt_ctrl.sv
// Page-descriptor table write sequencer: arbitrates refill/flush per thread,
// picks the victim way and drives the shared table write bus.
module eco32_core_ifu_icu_pt_ctrl
  import eco32_core_ifu_icu_pt_ctrl_pkg::*;
#(
  parameter int PAGE_ADDR_WIDTH = 5,
  parameter int WAYS            = 2,
  parameter bit INIT_FLUSH      = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  eco32_core_ifu_icu_pt_ctrl_if.slave bus
);

  localparam int PAW = PAGE_ADDR_WIDTH;
  localparam int WB  = way_bits(WAYS);
  localparam pt_state_e RST_STATE = INIT_FLUSH ? ST_INIT : ST_IDLE;

  pt_state_e state_q, state_d;

  logic [NTID-1:0]          rf_ack_q, rf_ack_d;
  logic [WB-1:0]            rf_way_q, rf_way_d;
  logic [NTID-1:0]          fl_ack_q, fl_ack_d;
  logic                     busy_q, busy_d;
  logic [WAYS-1:0]          wr_ena_q, wr_ena_d;
  logic [TID_W-1:0]         wr_tid_q, wr_tid_d;
  logic [PAW-1:0]           wr_page_q, wr_page_d;
  logic [DESC_W-1:0]        wr_desc_q, wr_desc_d;
  logic [NTID-1:0][WB-1:0]  victim_q, victim_d;

  logic [1:0]     fl_gnt, rf_gnt;
  logic           fl_upd, rf_upd;
  logic           fl_tid, rf_tid;
  logic [PAW:0]   init_nxt;
  logic [PAW-1:0] pg_nxt;

  eco32_core_ifu_icu_pt_arb u_fl_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.fl_req),
    .upd (fl_upd),
    .gnt (fl_gnt)
  );

  eco32_core_ifu_icu_pt_arb u_rf_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.rf_req),
    .upd (rf_upd),
    .gnt (rf_gnt)
  );

  // The registered write address doubles as the flush/init page counter.
  always_comb begin
    state_d   = state_q;
    rf_ack_d  = '0;
    rf_way_d  = '0;
    fl_ack_d  = '0;
    wr_ena_d  = '0;
    wr_tid_d  = '0;
    wr_page_d = '0;
    wr_desc_d = '0;
    victim_d  = victim_q;
    fl_upd    = 1'b0;
    rf_upd    = 1'b0;
    fl_tid    = fl_gnt[1];
    rf_tid    = rf_gnt[1];
    init_nxt  = {wr_tid_q, wr_page_q} + 1'b1;
    pg_nxt    = wr_page_q + 1'b1;

    unique case (state_q)
      ST_INIT: begin
        wr_ena_d = '1;
        if (wr_ena_q != '0) begin
          if ({wr_tid_q, wr_page_q} == '1) begin
            wr_ena_d = '0;
            state_d  = ST_HOLD;
          end else begin
            {wr_tid_d, wr_page_d} = init_nxt;
          end
        end
      end
      ST_IDLE: begin
        if (fl_gnt != '0) begin
          state_d          = ST_FLUSH;
          fl_upd           = 1'b1;
          wr_ena_d         = '1;
          wr_tid_d         = fl_tid;
          victim_d[fl_tid] = '0;
        end else if (rf_gnt != '0) begin
          state_d                    = ST_REFILL;
          rf_upd                     = 1'b1;
          wr_ena_d[victim_q[rf_tid]] = 1'b1;
          wr_tid_d                   = rf_tid;
          wr_page_d                  = bus.rf_page[rf_tid*PAW +: PAW];
          wr_desc_d                  = bus.rf_desc[rf_tid*DESC_W +: DESC_W];
          rf_ack_d[rf_tid]           = 1'b1;
          rf_way_d                   = victim_q[rf_tid];
          victim_d[rf_tid]           = victim_q[rf_tid] + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (wr_page_q == '1) begin
          state_d = ST_HOLD;
        end else begin
          wr_ena_d  = '1;
          wr_tid_d  = wr_tid_q;
          wr_page_d = pg_nxt;
          if (pg_nxt == '1) begin
            fl_ack_d[wr_tid_q] = 1'b1;
          end
        end
      end
      ST_REFILL: state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_STATE;
      rf_ack_q  <= '0;
      rf_way_q  <= '0;
      fl_ack_q  <= '0;
      busy_q    <= 1'b0;
      wr_ena_q  <= '0;
      wr_tid_q  <= '0;
      wr_page_q <= '0;
      wr_desc_q <= '0;
      victim_q  <= '0;
    end else begin
      state_q   <= state_d;
      rf_ack_q  <= rf_ack_d;
      rf_way_q  <= rf_way_d;
      fl_ack_q  <= fl_ack_d;
      busy_q    <= busy_d;
      wr_ena_q  <= wr_ena_d;
      wr_tid_q  <= wr_tid_d;
      wr_page_q <= wr_page_d;
      wr_desc_q <= wr_desc_d;
      victim_q  <= victim_d;
    end
  end

  assign bus.rf_ack        = rf_ack_q;
  assign bus.rf_way        = rf_way_q;
  assign bus.fl_ack        = fl_ack_q;
  assign bus.o_busy        = busy_q;
  assign bus.wr_ena        = wr_ena_q;
  assign bus.wr_tid        = wr_tid_q;
  assign bus.wr_page       = wr_page_q;
  assign bus.wr_descriptor = wr_desc_q;

endmodule

// File: tb/tb_eco32_core_ifu_icu_pt_ctrl.sv
// Bench for the ICU page-table write sequencer: directed vectors, corner sequences,
// then random traffic against a transaction-level model with table shadow.
module tb_eco32_core_ifu_icu_pt_ctrl;
  import eco32_core_ifu_icu_pt_ctrl_pkg::*;

  localparam int PAW  = 5;
  localparam int WAYS = 2;
  localparam int NPG  = 1 << PAW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eco32_core_ifu_icu_pt_ctrl_if #(.PAW(PAW), .WAYS(WAYS)) bus ();

  eco32_core_ifu_icu_pt_ctrl #(
    .PAGE_ADDR_WIDTH (PAW),
    .WAYS            (WAYS),
    .INIT_FLUSH      (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]     ena;
    logic           tid;
    logic [PAW-1:0] page;
    logic [35:0]    desc;
    logic [1:0]     rf_ack;
    logic           rf_way;
    logic [1:0]     fl_ack;
    logic           busy;
  } exp_t;

  typedef struct {
    int          tid;
    int          page;
    logic [35:0] desc;
    int          exp_ena;
    int          exp_way;
  } vec_t;

  int errors = 0;
  int checks = 0;

  exp_t        q[$];
  int          fl_last, rf_last;
  int          vic[2];
  logic [35:0] mtab[WAYS][2][NPG];
  logic [35:0] otab[WAYS][2][NPG];
  vec_t        vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s @%0t: got %0h want %0h", tag, nm, $time, act, exp);
    end
  endtask

  function automatic exp_t ex(input int ena, input int tid, input int page, input logic [35:0] desc,
                              input int rfa, input int way, input int fla, input int busy);
    exp_t e;
    e.ena    = 2'(ena);
    e.tid    = 1'(tid);
    e.page   = PAW'(page);
    e.desc   = desc;
    e.rf_ack = 2'(rfa);
    e.rf_way = 1'(way);
    e.fl_ack = 2'(fla);
    e.busy   = 1'(busy);
    return e;
  endfunction

  task automatic chk_bus(input string tag, input exp_t e);
    chk(tag, "wr_ena", 64'(bus.wr_ena), 64'(e.ena));
    chk(tag, "rf_ack", 64'(bus.rf_ack), 64'(e.rf_ack));
    chk(tag, "fl_ack", 64'(bus.fl_ack), 64'(e.fl_ack));
    chk(tag, "o_busy", 64'(bus.o_busy), 64'(e.busy));
    if (e.ena != 2'b00) begin
      chk(tag, "wr_tid", 64'(bus.wr_tid), 64'(e.tid));
      chk(tag, "wr_page", 64'(bus.wr_page), 64'(e.page));
      chk(tag, "wr_desc", 64'(bus.wr_descriptor), 64'(e.desc));
    end
    if (e.rf_ack != 2'b00) chk(tag, "rf_way", 64'(bus.rf_way), 64'(e.rf_way));
  endtask

  task automatic set_rf(input int t, input int page, input logic [35:0] desc);
    bus.rf_page[t*PAW +: PAW] = PAW'(page);
    bus.rf_desc[t*36 +: 36]   = desc;
  endtask

  // Reference: one decision per idle slot, each operation is its writes, a hold, an idle.
  task automatic model_decide();
    int w, way, pg;
    logic [35:0] d;
    if (bus.fl_req != 2'b00) begin
      w = (bus.fl_req == 2'b11) ? 1 - fl_last : (bus.fl_req[1] ? 1 : 0);
      fl_last = w;
      vic[w] = 0;
      for (int p = 0; p < NPG; p++) begin
        q.push_back(ex(3, w, p, '0, 0, 0, (p == NPG - 1) ? (1 << w) : 0, 1));
        for (int k = 0; k < WAYS; k++) mtab[k][w][p] = '0;
      end
      q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 1));
      q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 0));
    end else if (bus.rf_req != 2'b00) begin
      w = (bus.rf_req == 2'b11) ? 1 - rf_last : (bus.rf_req[1] ? 1 : 0);
      rf_last = w;
      way = vic[w];
      vic[w] = (vic[w] + 1) % WAYS;
      pg = int'(bus.rf_page[w*PAW +: PAW]);
      d  = bus.rf_desc[w*36 +: 36];
      mtab[way][w][pg] = d;
      q.push_back(ex(1 << way, w, pg, d, 1 << w, way, 0, 1));
      q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 1));
      q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 0));
    end else begin
      q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    exp_t e;
    logic [35:0] d;
    int t0way[3];

    vecs[0] = '{tid: 0, page: 5,  desc: 36'h8_1234_5678, exp_ena: 1, exp_way: 0};
    vecs[1] = '{tid: 0, page: 5,  desc: 36'h8_1234_5678, exp_ena: 2, exp_way: 1};
    vecs[2] = '{tid: 0, page: 5,  desc: 36'h8_1234_5678, exp_ena: 1, exp_way: 0};
    vecs[3] = '{tid: 1, page: 31, desc: 36'hF_0000_0001, exp_ena: 1, exp_way: 0};
    vecs[4] = '{tid: 1, page: 0,  desc: 36'h0_DEAD_BEEF, exp_ena: 2, exp_way: 1};

    bus.rf_req = '0; bus.fl_req = '0; bus.rf_page = '0; bus.rf_desc = '0;

    // Reset state, then the 64-entry init clear.
    tick(); tick(); tick();
    chk_bus("reset", ex(0, 0, 0, '0, 0, 0, 0, 0));
    chk("reset", "wr_page", 64'(bus.wr_page), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 2 * NPG; i++) begin
      tick();
      chk_bus("init", ex(3, i >> PAW, i % NPG, '0, 0, 0, 0, 1));
    end
    tick(); chk_bus("init_hold", ex(0, 0, 0, '0, 0, 0, 0, 1));
    tick(); chk_bus("init_idle", ex(0, 0, 0, '0, 0, 0, 0, 0));

    // Single refills: victim rotation per thread.
    foreach (vecs[i]) begin
      set_rf(vecs[i].tid, vecs[i].page, vecs[i].desc);
      bus.rf_req = 2'(1 << vecs[i].tid);
      tick();
      chk_bus("vec", ex(vecs[i].exp_ena, vecs[i].tid, vecs[i].page, vecs[i].desc,
                        1 << vecs[i].tid, vecs[i].exp_way, 0, 1));
      bus.rf_req = '0;
      tick(); chk_bus("vec_hold", ex(0, 0, 0, '0, 0, 0, 0, 1));
      tick(); chk_bus("vec_idle", ex(0, 0, 0, '0, 0, 0, 0, 0));
    end

    // Both threads held: alternate grants, independent victims.
    t0way = '{1, 0, 0};
    set_rf(0, 3, 36'hA_AAAA_0003);
    set_rf(1, 9, 36'hB_BBBB_0009);
    bus.rf_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      d = (k % 2 == 0) ? 36'hA_AAAA_0003 : 36'hB_BBBB_0009;
      chk_bus("rr", ex(1 << t0way[k], k % 2, (k % 2 == 0) ? 3 : 9, d, 1 << (k % 2), t0way[k], 0, 1));
      tick(); chk_bus("rr_hold", ex(0, 0, 0, '0, 0, 0, 0, 1));
      tick(); chk_bus("rr_idle", ex(0, 0, 0, '0, 0, 0, 0, 0));
    end
    bus.rf_req = '0;

    // Flush and refill for TID1 together: flush first, refill then lands in way 0.
    set_rf(1, 7, 36'h3_3333_3333);
    bus.fl_req = 2'b10;
    bus.rf_req = 2'b10;
    for (int i = 0; i < NPG; i++) begin
      tick();
      chk_bus("flush", ex(3, 1, i, '0, 0, 0, (i == NPG - 1) ? 2 : 0, 1));
    end
    bus.fl_req = '0;
    tick(); chk_bus("flush_hold", ex(0, 0, 0, '0, 0, 0, 0, 1));
    tick(); chk_bus("flush_idle", ex(0, 0, 0, '0, 0, 0, 0, 0));
    tick(); chk_bus("post_flush_rf", ex(1, 1, 7, 36'h3_3333_3333, 2, 0, 0, 1));
    bus.rf_req = '0;
    tick(); chk_bus("pf_hold", ex(0, 0, 0, '0, 0, 0, 0, 1));
    tick(); chk_bus("pf_idle", ex(0, 0, 0, '0, 0, 0, 0, 0));

    // Reset in the middle of a flush aborts without an ack.
    bus.fl_req = 2'b01;
    for (int i = 0; i <= 12; i++) begin
      tick();
      chk_bus("abort_flush", ex(3, 0, i, '0, 0, 0, 0, 1));
    end
    rst = 1'b0;
    #1;
    chk_bus("abort_rst", ex(0, 0, 0, '0, 0, 0, 0, 0));
    chk("abort_rst", "wr_page", 64'(bus.wr_page), 64'd0);
    bus.fl_req = '0;
    tick(); tick();
    rst = 1'b1;

    // Random traffic; the init clear must rerun first.
    fl_last = 1; rf_last = 1; vic = '{0, 0};
    for (int w = 0; w < WAYS; w++)
      for (int t = 0; t < 2; t++)
        for (int p = 0; p < NPG; p++) mtab[w][t][p] = '0;
    for (int i = 0; i < 2 * NPG; i++) q.push_back(ex(3, i >> PAW, i % NPG, '0, 0, 0, 0, 1));
    q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 1));
    q.push_back(ex(0, 0, 0, '0, 0, 0, 0, 0));

    for (int c = 0; c < 3000; c++) begin
      tick();
      e = q.pop_front();
      chk_bus("rand", e);
      for (int w = 0; w < WAYS; w++)
        if (bus.wr_ena[w]) otab[w][bus.wr_tid][bus.wr_page] = bus.wr_descriptor;
      if (e.rf_ack != 2'b00)
        for (int w = 0; w < WAYS; w++)
          chk("table", "entry", 64'(otab[w][e.tid][e.page]), 64'(mtab[w][e.tid][e.page]));
      for (int t = 0; t < 2; t++) begin
        if (bus.rf_ack[t]) bus.rf_req[t] = 1'b0;
        if (bus.fl_ack[t]) bus.fl_req[t] = 1'b0;
        if (!bus.rf_req[t] && $urandom_range(3) == 0) begin
          d = {4'($urandom_range(15)), $urandom()};
          set_rf(t, int'($urandom_range(NPG - 1)), d);
          bus.rf_req[t] = 1'b1;
        end
        if (!bus.fl_req[t] && $urandom_range(60) == 0) bus.fl_req[t] = 1'b1;
      end
      if (q.size() == 0) model_decide();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
